seven_seg_scan_ctrl: RTL and testbench
======================================

Name: seven_seg_scan_ctrl

Overview:
Time-multiplexing scan controller for a 4-digit common-anode seven-segment display. It drives one shared registered BCD-to-seven-segment decoder, which has 1-cycle latency and blanks all segments for codes 10-15. The controller sequences the four BCD digits onto the decoder and drives the active-low anodes and decimal point. It also inserts a blanking interval at each digit switch to prevent ghosting, and applies new display values only at frame boundaries.

Parameters:
REFRESH_CYCLES, 100000, cycles each digit is lit (1 ms at 100 MHz); must be >= 1
BLANK_CYCLES, 1000, cycles with all anodes off before each digit is lit; must be >= 2 to cover decoder latency
CNT_W, 17, counter width; must hold max(REFRESH_CYCLES, BLANK_CYCLES)-1

Ports:
clk  in  1  system clock; the only clock
rst_n  in  1  asynchronous, active-low reset
value_in  in  16  four BCD digits; [3:0] = digit 0 (rightmost) ... [15:12] = digit 3
dp_in  in  4  decimal-point request per digit, 1 = on
load  in  1  single-cycle strobe that captures value_in/dp_in into the pending register
lz_blank_en  in  1  1 = blank leading zeros
bcd  out  4  code to the shared decoder; 4'hF = blank
an  out  4  anode enables, active low; an[0] = digit 0
dp  out  1  decimal point, active low
frame_done  out  1  1-cycle pulse at the end of each full 4-digit scan

Behaviour:
- One clock; reset is asynchronous and active-low. All outputs are registered.
- Reset values: bcd=4'hF, an=4'b1111, dp=1, frame_done=0, state=BLANK, digit=0, cnt=0, shadow value/dp=0, pending value/dp=0, pend_valid=0.
- FSM has two states:
  - BLANK: an=1111, dp=1, bcd=display code of the current digit (preloads the decoder). cnt counts 0..BLANK_CYCLES-1, then the FSM goes to SHOW with cnt=0.
  - SHOW: an has only bit[digit] low, dp=~shadow_dp[digit], bcd is held. cnt counts 0..REFRESH_CYCLES-1. Then the FSM goes to BLANK, digit=digit+1 mod 4, and bcd updates to the new digit's code on that same edge.
- An anode never lights before the decoder output for that digit is valid: BLANK_CYCLES>=2 covers the 1-cycle decoder latency.
- When bcd changes, an is already 1111.
- Frame period = 4*(BLANK_CYCLES+REFRESH_CYCLES) cycles.
- Frame boundary is the SHOW->BLANK edge with digit==3:
  - frame_done=1 for exactly the following cycle.
  - digit wraps to 0.
  - If pend_valid, shadow <= pending and pend_valid <= 0.
- Load handling:
  - load mid-frame sets pending and pend_valid; the last load before the boundary wins.
  - load on the boundary cycle bypasses pending: value_in/dp_in go directly to shadow and pend_valid clears.
  - The displayed value never changes mid-frame.
- Display code for digit i:
  - Default: shadow nibble i.
  - If lz_blank_en=1 and nibble i and every higher nibble are 0, and i != 0, the code is 4'hF.
  - Digit 0 is never zero-blanked. Example: 0000 shows "   0".
- Nibbles 10-15 pass through unchanged, so the decoder blanks them. Zero-blanking does not blank dp.
- lz_blank_en is sampled at each digit's BLANK entry.
- When rst_n asserts mid-scan, all outputs go to reset values immediately; a pending load is lost. After release, the scan restarts at digit 0 in BLANK.

Test Plan:
Use REFRESH_CYCLES=8, BLANK_CYCLES=2 for all scenarios.
1. Reset release, load value 16'h1234 -> first frame shows 0000. From the second frame, an sequence is 1111(2)/1110(8)/1111(2)/1101(8)/1111(2)/1011(8)/1111(2)/0111(8) with bcd 4,3,2,1. Period 40 cycles; frame_done pulses every 40 cycles.
2. Check alignment of bcd to a registered decoder model: on every cycle with an != 1111, the decoded segments match the lit digit. bcd only changes while an=1111.
3. lz_blank_en=1, value 16'h0070 -> digits 3 and 2 get bcd=F, digit 1 gets 7, digit 0 gets 0. With value 16'h0000 -> only digit 0 shows 0.
4. Load 16'h1111 and then 16'h2222 mid-frame -> the current frame is unchanged and the next frame shows 2222. A load of 16'h5555 on the boundary cycle appears in the very next frame.
5. dp_in=4'b0100 -> dp=0 only during digit 2's SHOW window; dp=1 during every BLANK.
6. Assert rst_n low mid-SHOW of digit 2 -> same time step: an=1111, bcd=F, frame_done=0. After release, scanning restarts at digit 0 and displays 0000.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode seven-segment display driving one shared
// registered BCD decoder, with anti-ghost blanking and frame-aligned value updates.
module seven_seg_scan_ctrl #(
    parameter int unsigned REFRESH_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES   = 1000,
    parameter int unsigned CNT_W          = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        lz_blank_en,
    output logic [3:0]  bcd,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] BlankLast = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] ShowLast  = CNT_W'(REFRESH_CYCLES - 1);

    typedef enum logic {StBlank, StShow} state_e;

    state_e           state_q, state_d;
    logic [1:0]       digit_q, digit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      shadow_val_q, shadow_val_d;
    logic [3:0]       shadow_dp_q, shadow_dp_d;
    logic [15:0]      pend_val_q, pend_val_d;
    logic [3:0]       pend_dp_q, pend_dp_d;
    logic             pend_valid_q, pend_valid_d;
    logic [3:0]       bcd_d, an_d;
    logic             dp_d, frame_done_d;
    logic             blank_end, show_end, boundary;

    // Leading-zero blanking: digit idx blanks when it and all higher nibbles are zero.
    function automatic logic [3:0] disp_code(input logic [15:0] val, input logic [1:0] idx,
                                             input logic lz);
        logic [15:0] upper;
        upper = val >> {idx, 2'b00};
        if (lz && (idx != 2'd0) && (upper == 16'h0000)) begin
            return 4'hF;
        end
        return upper[3:0];
    endfunction

    always_comb begin
        blank_end = (state_q == StBlank) && (cnt_q == BlankLast);
        show_end  = (state_q == StShow) && (cnt_q == ShowLast);
        boundary  = show_end && (digit_q == 2'd3);

        state_d = state_q;
        digit_d = digit_q;
        cnt_d   = cnt_q + 1'b1;
        if (blank_end) begin
            state_d = StShow;
            cnt_d   = '0;
        end else if (show_end) begin
            state_d = StBlank;
            digit_d = digit_q + 2'd1;
            cnt_d   = '0;
        end

        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        if (boundary) begin
            pend_valid_d = 1'b0;
            if (load) begin
                shadow_val_d = value_in;
                shadow_dp_d  = dp_in;
            end else if (pend_valid_q) begin
                shadow_val_d = pend_val_q;
                shadow_dp_d  = pend_dp_q;
            end
        end else if (load) begin
            pend_val_d   = value_in;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end

        // Code for the next digit is presented while anodes are dark; the first BLANK cycle
        // also refreshes it so the digit shown right after reset is primed.
        bcd_d = bcd;
        if (show_end) begin
            bcd_d = disp_code(shadow_val_d, digit_d, lz_blank_en);
        end else if ((state_q == StBlank) && (cnt_q == '0)) begin
            bcd_d = disp_code(shadow_val_q, digit_q, lz_blank_en);
        end

        an_d         = 4'b1111;
        dp_d         = 1'b1;
        frame_done_d = boundary;
        if (state_d == StShow) begin
            an_d = 4'b1111 ^ (4'b0001 << digit_d);
            dp_d = ~shadow_dp_d[digit_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StBlank;
            digit_q      <= 2'd0;
            cnt_q        <= '0;
            shadow_val_q <= 16'h0000;
            shadow_dp_q  <= 4'h0;
            pend_val_q   <= 16'h0000;
            pend_dp_q    <= 4'h0;
            pend_valid_q <= 1'b0;
            bcd          <= 4'hF;
            an           <= 4'b1111;
            dp           <= 1'b1;
            frame_done   <= 1'b0;
        end else begin
            state_q      <= state_d;
            digit_q      <= digit_d;
            cnt_q        <= cnt_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            bcd          <= bcd_d;
            an           <= an_d;
            dp           <= dp_d;
            frame_done   <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench: a position-in-frame reference model queues expected outputs each cycle,
// a monitor pops and compares them together with a registered decoder model.
module tb_seven_seg_scan_ctrl;

    localparam int REFRESH = 8;
    localparam int BLANK   = 2;
    localparam int SLOT    = REFRESH + BLANK;
    localparam int FRAME   = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_blank_en;
    logic [3:0]  bcd, an;
    logic        dp, frame_done;

    seven_seg_scan_ctrl #(
        .REFRESH_CYCLES(REFRESH),
        .BLANK_CYCLES  (BLANK),
        .CNT_W         (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .load       (load),
        .lz_blank_en(lz_blank_en),
        .bcd        (bcd),
        .an         (an),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] bcd;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned k = 0;
    logic [15:0] cur_val, nxt_val;
    logic [3:0]  cur_dp, nxt_dp;
    logic        nxt_has;
    logic [6:0]  seg_q;
    logic [3:0]  prev_bcd = 4'hF;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at k=%0d: got %0h expected %0h", name, k, act, expv);
        end
    endtask

    function automatic logic [6:0] dec(input logic [3:0] c);
        case (c)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [3:0] exp_code(input logic [15:0] v, input int i, input logic lz);
        logic [15:0] upper;
        upper = v >> (4 * i);
        if (lz && i > 0 && upper == 16'h0000) return 4'hF;
        return upper[3:0];
    endfunction

    // Reference: k edges after reset release fixes the frame position directly.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k = 0;
            cur_val = 16'h0; cur_dp = 4'h0;
            nxt_val = 16'h0; nxt_dp = 4'h0; nxt_has = 1'b0;
            q.delete();
        end else begin
            int pos, d, w;
            exp_t e;
            k++;
            if (load) begin
                nxt_val = value_in; nxt_dp = dp_in; nxt_has = 1'b1;
            end
            if (k % FRAME == 0 && nxt_has) begin
                cur_val = nxt_val; cur_dp = nxt_dp; nxt_has = 1'b0;
            end
            pos = int'(k % FRAME);
            d = pos / SLOT;
            w = pos % SLOT;
            e.fd  = (pos == 0);
            e.bcd = exp_code(cur_val, d, lz_blank_en);
            if (w >= BLANK) begin
                e.an = ~(4'b0001 << d);
                e.dp = ~cur_dp[d];
            end else begin
                e.an = 4'b1111;
                e.dp = 1'b1;
            end
            q.push_back(e);
        end
    end

    always @(posedge clk) seg_q <= dec(bcd);

    always @(negedge clk) begin
        if (rst_n) begin
            chk("bcd_change_while_lit", int'(bcd == prev_bcd || an == 4'b1111), 1);
            prev_bcd = bcd;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("an", an, e.an);
                chk("bcd", bcd, e.bcd);
                chk("dp", dp, e.dp);
                chk("frame_done", frame_done, e.fd);
                if (e.an != 4'b1111) chk("seg", seg_q, dec(e.bcd));
            end
        end
    end

    task automatic wait_pos(input int m);
        int n = 0;
        while (int'(k % FRAME) != m && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("wait_timeout", 0, 1);
    endtask

    task automatic pulse(input logic [15:0] v, input logic [3:0] d);
        load = 1'b1; value_in = v; dp_in = d;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run_random(input int cycles, input logic lz_vals);
        for (int i = 0; i < cycles; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            if (lz_vals) v = v >> (4 * $urandom_range(0, 4));
            load = ($urandom_range(0, 15) == 0);
            value_in = v;
            dp_in = 4'($urandom);
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; value_in = 16'h0; dp_in = 4'h0; lz_blank_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_an", an, 4'hF);
        chk("reset_bcd", bcd, 4'hF);
        chk("reset_dp", dp, 1);
        chk("reset_frame_done", frame_done, 0);
        rst_n = 1'b1;

        wait_pos(5);  pulse(16'h1234, 4'b0100);
        repeat (2 * FRAME) @(negedge clk);
        wait_pos(10); pulse(16'h1111, 4'b0001);
        wait_pos(20); pulse(16'h2222, 4'b0010);
        wait_pos(39); pulse(16'h5555, 4'b1000);
        repeat (FRAME + 5) @(negedge clk);
        run_random(6 * FRAME, 1'b0);

        // Pending load followed by reset mid-SHOW of digit 2: load is lost.
        wait_pos(22); pulse(16'h9999, 4'b1111);
        wait_pos(25);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_an", an, 4'hF);
        chk("async_rst_bcd", bcd, 4'hF);
        chk("async_rst_frame_done", frame_done, 0);
        chk("async_rst_dp", dp, 1);
        lz_blank_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        wait_pos(5); pulse(16'h0070, 4'b0000);
        repeat (2 * FRAME) @(negedge clk);
        wait_pos(5); pulse(16'h0000, 4'b0001);
        repeat (2 * FRAME) @(negedge clk);
        run_random(5 * FRAME, 1'b1);
        repeat (FRAME) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
